// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring) unit driving HI/LO.
// A start accepted at edge E yields a one-cycle done at E+32; a divide by zero signals done right after E.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_start,
   input  logic        div_start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt;
   logic [64:0] r_booth;
   logic [31:0] r_mcand, r_rem, r_quo, r_dvsr, r_hi, r_lo;
   logic        r_sign_q, r_sign_r, r_div_zero;

   logic        w_last, w_div_by_zero;
   logic [32:0] w_acc_ext, w_sum, w_rem_sh, w_diff;
   logic [64:0] w_booth_nxt;
   logic [31:0] w_rem_nxt, w_quo_nxt, w_abs_a, w_abs_b;

   assign w_last  = (r_cnt == 6'd31);
   assign w_abs_a = a[31] ? -a : a;
   assign w_abs_b = b[31] ? -b : b;

   // Accumulator is sign-extended to 33 bits so subtracting 0x80000000 cannot overflow.
   always_comb begin
      w_acc_ext = {r_booth[64], r_booth[64:33]};
      w_sum     = w_acc_ext;
      case (r_booth[1:0])
         2'b01:   w_sum = w_acc_ext + {r_mcand[31], r_mcand};
         2'b10:   w_sum = w_acc_ext - {r_mcand[31], r_mcand};
         default: w_sum = w_acc_ext;
      endcase
      w_booth_nxt = {w_sum, r_booth[32:1]};
   end

   always_comb begin
      w_rem_sh  = {r_rem, r_quo[31]};
      w_diff    = w_rem_sh - {1'b0, r_dvsr};
      w_rem_nxt = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
      w_quo_nxt = {r_quo[30:0], ~w_diff[32]};
   end

   assign w_div_by_zero = (r_state == S_IDLE) && !mult_start && div_start && (b == 32'd0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (mult_start)             w_state_nxt = S_MULT;
            else if (div_start)         w_state_nxt = (b == 32'd0) ? S_DONE : S_DIV;
         end
         S_MULT:  if (w_last) w_state_nxt = S_DONE;
         S_DIV:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 6'd0;
         r_booth    <= 65'd0;
         r_mcand    <= 32'd0;
         r_rem      <= 32'd0;
         r_quo      <= 32'd0;
         r_dvsr     <= 32'd0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_div_zero <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div_zero <= w_div_by_zero;
         case (r_state)
            S_IDLE: begin
               if (mult_start) begin
                  r_booth <= {32'd0, b, 1'b0};
                  r_mcand <= a;
                  r_cnt   <= 6'd0;
               end else if (div_start && (b != 32'd0)) begin
                  r_rem    <= 32'd0;
                  r_quo    <= w_abs_a;
                  r_dvsr   <= w_abs_b;
                  r_sign_q <= a[31] ^ b[31];
                  r_sign_r <= a[31];
                  r_cnt    <= 6'd0;
               end
            end
            S_MULT: begin
               r_booth <= w_booth_nxt;
               r_cnt   <= r_cnt + 6'd1;
               if (w_last) begin
                  r_hi <= w_booth_nxt[64:33];
                  r_lo <= w_booth_nxt[32:1];
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 6'd1;
               if (w_last) begin
                  r_lo <= r_sign_q ? -w_quo_nxt : w_quo_nxt;
                  r_hi <= r_sign_r ? -w_rem_nxt : w_rem_nxt;
               end
            end
            S_DONE:  r_cnt <= 6'd0;
            default: r_cnt <= 6'd0;
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = (r_state == S_MULT) || (r_state == S_DIV);
   assign done     = (r_state == S_DONE);
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: signs, divide by zero, overflow, reset and ignored starts.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mult_start, div_start;
   logic [31:0] a, b;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int n_cmp = 0;
   int n_err = 0;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
      .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulses a start for one cycle; returns half a cycle after the accepting edge.
   task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      mult_start = m; div_start = d; a = av; b = bv;
      @(negedge clk);
      mult_start = 1'b0; div_start = 1'b0;
   endtask

   // Waits (bounded) for done; cyc = negedges elapsed since the accept-edge sample point.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input string tag, input logic m, input logic d,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      start_op(m, d, av, bv);
      wait_done(cyc);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_lat"}, cyc, 32'd32);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int cyc;
      int pulses;
      reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a = 32'd0; b = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
      reset = 1'b0;

      run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      // Reset lands on the 10th iteration edge.
      start_op(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (9) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_hi", hi, 32'd0);
      chk("mid_lo", lo, 32'd0);
      chk("mid_flags", {30'd0, busy, done}, 32'd0);

      run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
      run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run_op("mul_5_6", 1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30);

      start_op(1'b0, 1'b1, 32'd9, 32'd0);
      wait_done(cyc);
      chk("dz_lat", cyc, 32'd0);
      chk("dz_flags", {29'd0, busy, done, div_zero}, 32'd3);
      chk("dz_hi", hi, 32'd0);
      chk("dz_lo", lo, 32'd30);
      @(negedge clk);
      chk("dz_pulse", {29'd0, busy, done, div_zero}, 32'd0);

      run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      run_op("both", 1'b1, 1'b1, 32'd6, 32'd4, 32'd0, 32'd24);

      // Second mult_start arrives five cycles into a divide and must be dropped.
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      mult_start = 1'b1; a = 32'd3; b = 32'd3;
      @(negedge clk);
      mult_start = 1'b0;
      cyc = 5;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("ign_lat", cyc, 32'd32);
      chk("ign_lo", lo, 32'd14);
      chk("ign_hi", hi, 32'd2);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("ign_pulses", pulses, 32'd0);
      chk("ign_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
